serial_receiver: RTL and testbench

Serial-in/parallel-out frame receiver: the receiving end of the single-wire serial link driven from the team's shift-register datapath. It samples one bit per clock on `i`, detects a start bit, assembles a W-bit word in an internal shift register (MSB-first or LSB-first), checks the stop bit, and presents the word on `q` with a valid/acknowledge handshake. It sits between the serial line and the parallel consumer logic, reporting framing errors and overruns.

---
 rtl/serial_receiver.sv | 96 +++++++++
 tb/tb_serial_receiver.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/serial_receiver.sv
// rtl/serial_receiver.sv - serial-in/parallel-out frame receiver with valid/ack handshake
module serial_receiver #(
  parameter int W = 8
) (
  input  logic         c,
  input  logic         rst,
  input  logic         i,
  input  logic         m,
  input  logic         a,
  output logic [W-1:0] q,
  output logic         v,
  output logic         fe,
  output logic         ovr,
  output logic         busy
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  sh_q;
  logic [W-1:0]  sh_d;
  logic [W-1:0]  q_q;
  logic          m_q;
  logic          v_q;
  logic          fe_q;
  logic          ovr_q;
  logic          busy_q;

  // Either shift direction leaves the word in natural bit order after W bits.
  always_comb begin
    sh_d = sh_q;
    if (m_q) sh_d = {sh_q[W-2:0], i};
    else     sh_d = {i, sh_q[W-1:1]};
  end

  always_ff @(posedge c) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      q_q     <= '0;
      m_q     <= 1'b0;
      v_q     <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      fe_q <= 1'b0;
      if (v_q && a) v_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i) begin
            m_q     <= m;
            cnt_q   <= '0;
            state_q <= DATA;
            busy_q  <= 1'b1;
          end
        end
        DATA: begin
          sh_q  <= sh_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) state_q <= STOP;
        end
        STOP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (!i) begin
            // A same-edge ack frees the holding register, so the new word wins.
            if (!v_q || a) begin
              q_q <= sh_q;
              v_q <= 1'b1;
            end else begin
              ovr_q <= 1'b1;
            end
          end else begin
            fe_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign q    = q_q;
  assign v    = v_q;
  assign fe   = fe_q;
  assign ovr  = ovr_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_serial_receiver.sv
// tb/tb_serial_receiver.sv - directed table-driven bench for serial_receiver
module tb_serial_receiver;

  localparam int W = 8;

  logic         c = 1'b0;
  logic         rst = 1'b1;
  logic         i = 1'b0;
  logic         m = 1'b0;
  logic         a = 1'b0;
  logic [W-1:0] q;
  logic         v;
  logic         fe;
  logic         ovr;
  logic         busy;

  int checks = 0;
  int errors = 0;

  serial_receiver #(.W(W)) dut (
    .c(c), .rst(rst), .i(i), .m(m), .a(a),
    .q(q), .v(v), .fe(fe), .ovr(ovr), .busy(busy)
  );

  always #5 c = ~c;

  typedef struct {
    logic         mm;
    logic [W-1:0] data;
    logic         stop;
    logic         ack;
    logic         clr;
    logic [W-1:0] eq;
    logic         ev;
    logic         efe;
    logic         eovr;
  } vec_t;

  vec_t tbl [7];

  logic v_before_stop;
  logic busy_after_start;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  // Drives one frame; m is toggled during data bits to show it is latched at the start bit.
  task automatic send_frame(input logic mm, input logic [W-1:0] data,
                            input logic stop, input logic ack_stop);
    i = 1'b1; m = mm; a = 1'b0;
    tick();
    busy_after_start = busy;
    for (int j = 0; j < W; j++) begin
      i = mm ? data[W-1-j] : data[j];
      m = ~mm;
      tick();
    end
    v_before_stop = v;
    i = stop; a = ack_stop;
    tick();
    i = 1'b0; a = 1'b0; m = mm;
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    tick();
    tick();
    chk("reset_q", q, 0);
    chk("reset_flags", {v, fe, ovr, busy}, 0);
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      chk("idle_q", q, 0);
      chk("idle_flags", {v, fe, ovr, busy}, 0);
    end

    // Latency: v still low after the last data edge, high after the stop edge.
    send_frame(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("lat_busy_start", busy_after_start, 1);
    chk("lat_v_before_stop", v_before_stop, 0);
    chk("lat_v_after_stop", v, 1);
    chk("lat_busy_after_stop", busy, 0);
    chk("lat_q", q, 8'hA5);
    a = 1'b1;
    tick();
    a = 1'b0;
    chk("lat_ack_clears_v", v, 0);

    for (int k = 0; k < 7; k++) begin
      send_frame(tbl[k].mm, tbl[k].data, tbl[k].stop, tbl[k].ack);
      chk($sformatf("vec%0d_q", k), q, tbl[k].eq);
      chk($sformatf("vec%0d_v", k), v, tbl[k].ev);
      chk($sformatf("vec%0d_fe", k), fe, tbl[k].efe);
      chk($sformatf("vec%0d_ovr", k), ovr, tbl[k].eovr);
      chk($sformatf("vec%0d_busy", k), busy, 0);
      a = tbl[k].clr;
      tick();
      a = 1'b0;
      chk($sformatf("vec%0d_v_next", k), v, tbl[k].clr ? 1'b0 : tbl[k].ev);
      chk($sformatf("vec%0d_fe_next", k), fe, 0);
      chk($sformatf("vec%0d_q_hold", k), q, tbl[k].eq);
    end

    // Back-to-back frames with an ack landing on the second stop edge.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_clears_ovr", ovr, 0);
    send_frame(1'b1, 8'h11, 1'b0, 1'b0);
    chk("b2b_first_q", q, 8'h11);
    send_frame(1'b1, 8'h22, 1'b0, 1'b1);
    chk("b2b_sim_ack_q", q, 8'h22);
    chk("b2b_sim_ack_v", v, 1);
    chk("b2b_sim_ack_ovr", ovr, 0);

    // Reset after four data bits discards the partial frame.
    i = 1'b1; m = 1'b1;
    tick();
    for (int j = 0; j < 4; j++) begin
      i = j[0];
      tick();
    end
    rst = 1'b1; i = 1'b0;
    tick();
    chk("midrst_q", q, 0);
    chk("midrst_flags", {v, fe, ovr, busy}, 0);
    rst = 1'b0;
    tick();
    chk("midrst_idle_busy", busy, 0);
    send_frame(1'b1, 8'hF0, 1'b0, 1'b0);
    chk("midrst_next_q", q, 8'hF0);
    chk("midrst_next_v", v, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
